sram_axi_bridge_np: RTL and testbench
=====================================

// Module: sram_axi_bridge_np
// PURPOSE
//  Parametrised SRAM-like -> AXI3 master bridge for NPORT requesters (port 0 = inst, port 1 = data, ...).
//  Fixed-priority arbitration, up to RD_OUTST outstanding reads per port, one outstanding write.
//  Read-after-write address hazard protection. Sits between CPU core and the AXI crossbar/slave.
// PARAMETERS
//  NPORT     2   number of SRAM-like request ports (1..8); port index = AXI ID
//  ADDR_W    32  address width
//  DATA_W    32  data width (wstrb width = DATA_W/8)
//  ID_W      4   AXI ID width; must satisfy 2**ID_W >= NPORT
//  RD_OUTST  2   max in-flight reads per port (1..7)
// PORTS
//  aclk          in   1               clock
//  aresetn       in   1               reset; asynchronous assert, active-low
//  s_req         in   NPORT           per-port request
//  s_wr          in   NPORT           1=write 0=read
//  s_size        in   2*NPORT         0:1B 1:2B 2:4B
//  s_wstrb       in   NPORT*DATA_W/8  write byte enables
//  s_addr        in   NPORT*ADDR_W    request address
//  s_wdata       in   NPORT*DATA_W    write data
//  s_addr_ok     out  NPORT           request accepted (1-cycle, comb.)
//  s_data_ok     out  NPORT           read data returned / write completed
//  s_rdata       out  NPORT*DATA_W    read data (valid with s_data_ok)
//  arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid out; arready in
//  rid/rdata/rvalid in; rready out
//  awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awvalid out; awready in
//  wid/wdata/wstrb/wlast/wvalid out; wready in
//  bid/bvalid in; bready out
// BEHAVIOUR
//  Reset (aresetn=0, async): arvalid=awvalid=wvalid=0, bready=0, rready=1, s_addr_ok=s_data_ok=0,
//   all per-port read counters=0, FSMs to idle; in-flight transactions dropped (slave reset with us).
//  Constants: ar/awlen=0, ar/awburst=2'b01, lock/cache/prot=0, wlast=1, ar/awsize={1'b0,size}.
//  Arbitration: each cycle at most one s_addr_ok; highest-index port with an acceptable request wins.
//  Read acceptable: AR FSM AR_IDLE, port counter < RD_OUTST, no RAW hazard.
//  RAW hazard: write FSM != W_IDLE and addr[ADDR_W-1:2] equals pending write addr[ADDR_W-1:2].
//  Write acceptable: write FSM W_IDLE (reads never block writes).
//  AR FSM: AR_IDLE --accept--> AR_SEND (latch addr/size/id=port); arvalid=1 until arready, then AR_IDLE.
//   Next read acceptable the cycle after the arready handshake.
//  Read counter[p]: +1 on read accept, -1 on rvalid&&rid==p; both same cycle -> unchanged.
//  R channel: rready=1 always; s_data_ok[rid]=rvalid, s_rdata[rid]=rdata same cycle (0-cycle latency).
//   Per-port data order = per-port request order (AXI same-ID ordering). rid>=NPORT: ignored.
//  Write FSM: W_IDLE --accept--> W_SEND (latch addr/data/strb/size/id); awvalid and wvalid raised together,
//   each dropped independently on its own handshake; when both done -> W_RESP, bready=1;
//   bvalid -> s_data_ok[bid]=1 for one cycle, W_IDLE. Next write acceptable the cycle after.
//  Latched ar/aw/w payload stable while valid high (AXI rule); requester may change inputs after addr_ok.
//  Minimum read latency: req(addr_ok) -> arvalid next cycle -> data_ok on rvalid.
// TESTING
//  1 Single read port0 addr 0x1C000000, arready=1, rvalid 2 cycles later rdata=0xDEADBEEF
//    -> arid=0, arsize=2, s_data_ok[0]=1 with s_rdata=0xDEADBEEF.
//  2 Ports 0 and 1 request reads same cycle -> port1 addr_ok first, port0 accepted after port1 arready.
//  3 Port1 write 0x100 (wstrb=4'b0011, data 0x1234) then read 0x100: read addr_ok held 0 until bvalid;
//    awready delayed 3 cycles after wready -> wvalid drops first, awvalid holds; bready only after both.
//  4 Port0 issues RD_OUTST=2 reads with rvalid stalled -> third read addr_ok=0 until one rvalid rid=0.
//  5 Interleaved returns rid=1 then rid=0 -> s_data_ok[1] then s_data_ok[0], correct rdata each.
//  6 Assert aresetn=0 mid-write (awvalid=1) -> awvalid/wvalid drop immediately, counters 0, idle after release.

Source files
------------

// File: rtl/sram_axi_bridge_np.sv
// Bridge from NPORT SRAM-like requesters to one AXI3 master.
// Fixed priority (highest index wins), per-port read credits, a single write in flight, and read-after-write blocking.
module sram_axi_bridge_np #(
  parameter int NPORT    = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int ID_W     = 4,
  parameter int RD_OUTST = 2
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [NPORT-1:0]            s_req,
  input  logic [NPORT-1:0]            s_wr,
  input  logic [2*NPORT-1:0]          s_size,
  input  logic [NPORT*DATA_W/8-1:0]   s_wstrb,
  input  logic [NPORT*ADDR_W-1:0]     s_addr,
  input  logic [NPORT*DATA_W-1:0]     s_wdata,
  output logic [NPORT-1:0]            s_addr_ok,
  output logic [NPORT-1:0]            s_data_ok,
  output logic [NPORT*DATA_W-1:0]     s_rdata,
  output logic [ID_W-1:0]             arid,
  output logic [ADDR_W-1:0]           araddr,
  output logic [3:0]                  arlen,
  output logic [2:0]                  arsize,
  output logic [1:0]                  arburst,
  output logic [1:0]                  arlock,
  output logic [3:0]                  arcache,
  output logic [2:0]                  arprot,
  output logic                        arvalid,
  input  logic                        arready,
  input  logic [ID_W-1:0]             rid,
  input  logic [DATA_W-1:0]           rdata,
  input  logic                        rvalid,
  output logic                        rready,
  output logic [ID_W-1:0]             awid,
  output logic [ADDR_W-1:0]           awaddr,
  output logic [3:0]                  awlen,
  output logic [2:0]                  awsize,
  output logic [1:0]                  awburst,
  output logic [1:0]                  awlock,
  output logic [3:0]                  awcache,
  output logic [2:0]                  awprot,
  output logic                        awvalid,
  input  logic                        awready,
  output logic [ID_W-1:0]             wid,
  output logic [DATA_W-1:0]           wdata,
  output logic [DATA_W/8-1:0]         wstrb,
  output logic                        wlast,
  output logic                        wvalid,
  input  logic                        wready,
  input  logic [ID_W-1:0]             bid,
  input  logic                        bvalid,
  output logic                        bready
);

  localparam int STRB_W = DATA_W / 8;
  localparam int PW     = (NPORT > 1) ? $clog2(NPORT) : 1;

  typedef enum logic {AR_IDLE, AR_SEND} ar_state_t;
  typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_t;

  ar_state_t ar_state_q, ar_state_d;
  w_state_t  w_state_q, w_state_d;

  logic [ADDR_W-1:0] ar_addr_q, ar_addr_d;
  logic [1:0]        ar_size_q, ar_size_d;
  logic [PW-1:0]     ar_id_q, ar_id_d;

  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [STRB_W-1:0] wr_strb_q, wr_strb_d;
  logic [1:0]        wr_size_q, wr_size_d;
  logic [PW-1:0]     wr_id_q, wr_id_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;

  logic [2:0]        rd_cnt_q [NPORT];
  logic [NPORT-1:0]  rd_ok;
  logic              wr_ok;

  logic              grant_valid;
  logic              grant_wr;
  logic [PW-1:0]     grant_idx;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [STRB_W-1:0] sel_strb;
  logic [1:0]        sel_size;

  assign wr_ok = (w_state_q == W_IDLE);

  genvar gi;
  generate
    for (gi = 0; gi < NPORT; gi++) begin : g_port
      logic       hazard;
      logic       inc;
      logic       dec;
      logic [2:0] cnt_d;

      // Word-granular compare: any overlap within the pending write's word stalls the read.
      assign hazard = (w_state_q != W_IDLE) &&
                      (s_addr[gi*ADDR_W+2 +: ADDR_W-2] == wr_addr_q[ADDR_W-1:2]);
      assign rd_ok[gi] = (ar_state_q == AR_IDLE) && (rd_cnt_q[gi] < 3'(RD_OUTST)) && !hazard;

      assign inc   = s_addr_ok[gi] && !s_wr[gi];
      assign dec   = rvalid && (rid == ID_W'(gi));
      assign cnt_d = rd_cnt_q[gi] + {2'b00, inc} - {2'b00, dec};

      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) rd_cnt_q[gi] <= '0;
        else          rd_cnt_q[gi] <= cnt_d;
      end

      assign s_addr_ok[gi] = grant_valid && (grant_idx == PW'(gi));
      assign s_data_ok[gi] = (rvalid && (rid == ID_W'(gi))) ||
                             ((w_state_q == W_RESP) && bvalid && (bid == ID_W'(gi)));
      assign s_rdata[gi*DATA_W +: DATA_W] = (rvalid && (rid == ID_W'(gi))) ? rdata : '0;
    end
  endgenerate

  // Later iterations override earlier ones, so the highest-index eligible port wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_wr    = 1'b0;
    grant_idx   = '0;
    sel_addr    = '0;
    sel_wdata   = '0;
    sel_strb    = '0;
    sel_size    = '0;
    for (int p = 0; p < NPORT; p++) begin
      if (s_req[p] && (s_wr[p] ? wr_ok : rd_ok[p])) begin
        grant_valid = 1'b1;
        grant_wr    = s_wr[p];
        grant_idx   = PW'(p);
        sel_addr    = s_addr[p*ADDR_W +: ADDR_W];
        sel_wdata   = s_wdata[p*DATA_W +: DATA_W];
        sel_strb    = s_wstrb[p*STRB_W +: STRB_W];
        sel_size    = s_size[2*p +: 2];
      end
    end
  end

  always_comb begin
    ar_state_d = ar_state_q;
    ar_addr_d  = ar_addr_q;
    ar_size_d  = ar_size_q;
    ar_id_d    = ar_id_q;
    case (ar_state_q)
      AR_IDLE: if (grant_valid && !grant_wr) begin
        ar_state_d = AR_SEND;
        ar_addr_d  = sel_addr;
        ar_size_d  = sel_size;
        ar_id_d    = grant_idx;
      end
      AR_SEND: if (arready) ar_state_d = AR_IDLE;
      default: ar_state_d = AR_IDLE;
    endcase
  end

  always_comb begin
    w_state_d = w_state_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_strb_d = wr_strb_q;
    wr_size_d = wr_size_q;
    wr_id_d   = wr_id_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (w_state_q)
      W_IDLE: if (grant_valid && grant_wr) begin
        w_state_d = W_SEND;
        wr_addr_d = sel_addr;
        wr_data_d = sel_wdata;
        wr_strb_d = sel_strb;
        wr_size_d = sel_size;
        wr_id_d   = grant_idx;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
      end
      W_SEND: begin
        aw_done_d = aw_done_q || awready;
        w_done_d  = w_done_q || wready;
        if (aw_done_d && w_done_d) w_state_d = W_RESP;
      end
      W_RESP: if (bvalid) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ar_state_q <= AR_IDLE;
      ar_addr_q  <= '0;
      ar_size_q  <= '0;
      ar_id_q    <= '0;
      w_state_q  <= W_IDLE;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_strb_q  <= '0;
      wr_size_q  <= '0;
      wr_id_q    <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      ar_state_q <= ar_state_d;
      ar_addr_q  <= ar_addr_d;
      ar_size_q  <= ar_size_d;
      ar_id_q    <= ar_id_d;
      w_state_q  <= w_state_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_strb_q  <= wr_strb_d;
      wr_size_q  <= wr_size_d;
      wr_id_q    <= wr_id_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

  assign arid    = ID_W'(ar_id_q);
  assign araddr  = ar_addr_q;
  assign arlen   = 4'd0;
  assign arsize  = {1'b0, ar_size_q};
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign arvalid = (ar_state_q == AR_SEND);
  assign rready  = 1'b1;

  assign awid    = ID_W'(wr_id_q);
  assign awaddr  = wr_addr_q;
  assign awlen   = 4'd0;
  assign awsize  = {1'b0, wr_size_q};
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign awvalid = (w_state_q == W_SEND) && !aw_done_q;

  assign wid     = ID_W'(wr_id_q);
  assign wdata   = wr_data_q;
  assign wstrb   = wr_strb_q;
  assign wlast   = 1'b1;
  assign wvalid  = (w_state_q == W_SEND) && !w_done_q;
  assign bready  = (w_state_q == W_RESP);

endmodule

// File: tb/tb_sram_axi_bridge_np.sv
// Directed bench for sram_axi_bridge_np: inputs change just after each falling edge,
// and outputs are checked 1 ns later, well away from the rising edge.
module tb_sram_axi_bridge_np;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [1:0]  s_req, s_wr, s_addr_ok, s_data_ok;
  logic [3:0]  s_size;
  logic [7:0]  s_wstrb;
  logic [63:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  arid, awid, wid, rid, bid;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [3:0]  arlen, awlen, arcache, awcache, wstrb;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  int errors = 0;
  int checks = 0;

  always #5 aclk = ~aclk;

  sram_axi_bridge_np #(.NPORT(2), .ADDR_W(32), .DATA_W(32), .ID_W(4), .RD_OUTST(2)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_wstrb(s_wstrb),
    .s_addr(s_addr), .s_wdata(s_wdata),
    .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bvalid(bvalid), .bready(bready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_port(input int p, input logic wr, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    s_wr[p]             = wr;
    s_size[2*p +: 2]    = size;
    s_addr[32*p +: 32]  = addr;
    s_wdata[32*p +: 32] = data;
    s_wstrb[4*p +: 4]   = strb;
  endtask

  task automatic step();
    @(negedge aclk);
  endtask

  initial begin
    aresetn = 1'b0;
    s_req = '0; s_wr = '0; s_size = '0; s_wstrb = '0; s_addr = '0; s_wdata = '0;
    arready = 0; rid = '0; rdata = '0; rvalid = 0;
    awready = 0; wready = 0; bid = '0; bvalid = 0;

    // Reset state
    step(); step(); #1;
    chk("rst_arvalid", arvalid, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_bready", bready, 0);
    chk("rst_rready", rready, 1);
    chk("rst_addr_ok", s_addr_ok, 0);
    chk("rst_data_ok", s_data_ok, 0);
    step(); aresetn = 1'b1;

    // 1: single read on port 0
    step();
    set_port(0, 0, 2'd2, 32'h1C00_0000, 0, 0);
    s_req = 2'b01; arready = 1; #1;
    chk("t1_addr_ok", s_addr_ok, 2'b01);
    step(); s_req = 0; #1;
    chk("t1_arvalid", arvalid, 1);
    chk("t1_araddr", araddr, 32'h1C00_0000);
    chk("t1_arid", arid, 0);
    chk("t1_arsize", arsize, 3'd2);
    chk("t1_arlen", arlen, 0);
    chk("t1_arburst", arburst, 2'b01);
    step(); #1;
    chk("t1_arvalid_drop", arvalid, 0);
    step(); rvalid = 1; rid = 0; rdata = 32'hDEAD_BEEF; #1;
    chk("t1_data_ok", s_data_ok, 2'b01);
    chk("t1_rdata", s_rdata[31:0], 32'hDEAD_BEEF);
    step(); rvalid = 0; arready = 0;

    // 2: simultaneous reads, port 1 has priority
    set_port(0, 0, 2'd2, 32'h0000_1000, 0, 0);
    set_port(1, 0, 2'd2, 32'h0000_2000, 0, 0);
    s_req = 2'b11; #1;
    chk("t2_addr_ok_p1", s_addr_ok, 2'b10);
    step(); s_req = 2'b01; #1;
    chk("t2_addr_ok_busy", s_addr_ok, 2'b00);
    chk("t2_arid1", arid, 1);
    chk("t2_araddr1", araddr, 32'h0000_2000);
    arready = 1;
    step(); #1;
    chk("t2_addr_ok_p0", s_addr_ok, 2'b01);
    step(); s_req = 0; #1;
    chk("t2_arvalid0", arvalid, 1);
    chk("t2_arid0", arid, 0);
    chk("t2_araddr0", araddr, 32'h0000_1000);
    step(); arready = 0;

    // 5: interleaved returns, rid=1 then rid=0
    rvalid = 1; rid = 1; rdata = 32'h2222_2222; #1;
    chk("t5_data_ok1", s_data_ok, 2'b10);
    chk("t5_rdata1", s_rdata[63:32], 32'h2222_2222);
    step(); rid = 0; rdata = 32'h1111_1111; #1;
    chk("t5_data_ok0", s_data_ok, 2'b01);
    chk("t5_rdata0", s_rdata[31:0], 32'h1111_1111);
    step(); rvalid = 0;

    // 3: write then read same address; W completes before AW
    set_port(1, 1, 2'd1, 32'h0000_0100, 32'h0000_1234, 4'b0011);
    s_req = 2'b10; #1;
    chk("t3_wr_addr_ok", s_addr_ok, 2'b10);
    step();
    set_port(1, 0, 2'd2, 32'h0000_0100, 0, 0); #1;
    chk("t3_raw_block", s_addr_ok, 2'b00);
    chk("t3_awvalid", awvalid, 1);
    chk("t3_wvalid", wvalid, 1);
    chk("t3_awaddr", awaddr, 32'h0000_0100);
    chk("t3_awid", awid, 1);
    chk("t3_awsize", awsize, 3'd1);
    chk("t3_wdata", wdata, 32'h0000_1234);
    chk("t3_wstrb", wstrb, 4'b0011);
    chk("t3_wid", wid, 1);
    chk("t3_wlast", wlast, 1);
    wready = 1;
    step(); wready = 0; #1;
    chk("t3_wvalid_drop", wvalid, 0);
    chk("t3_awvalid_hold", awvalid, 1);
    chk("t3_bready_early", bready, 0);
    step(); #1;
    chk("t3_awvalid_hold2", awvalid, 1);
    chk("t3_raw_block2", s_addr_ok, 2'b00);
    step(); awready = 1; #1;
    chk("t3_awvalid_hold3", awvalid, 1);
    chk("t3_bready_pre", bready, 0);
    step(); awready = 0; #1;
    chk("t3_awvalid_drop", awvalid, 0);
    chk("t3_bready", bready, 1);
    chk("t3_raw_block3", s_addr_ok, 2'b00);
    bvalid = 1; bid = 1; #1;
    chk("t3_wr_data_ok", s_data_ok, 2'b10);
    chk("t3_raw_block4", s_addr_ok, 2'b00);
    step(); bvalid = 0; #1;
    chk("t3_rd_addr_ok", s_addr_ok, 2'b10);
    chk("t3_bready_drop", bready, 0);
    step(); s_req = 0; #1;
    chk("t3_araddr", araddr, 32'h0000_0100);
    chk("t3_arid", arid, 1);
    arready = 1;
    step(); arready = 0; rvalid = 1; rid = 1; rdata = 32'h0000_5678; #1;
    chk("t3_rd_data_ok", s_data_ok, 2'b10);
    chk("t3_rdata", s_rdata[63:32], 32'h0000_5678);
    step(); rvalid = 0;

    // 4: port 0 read credit limit
    set_port(0, 0, 2'd2, 32'h0000_0300, 0, 0);
    s_req = 2'b01; arready = 1; #1;
    chk("t4_rd1_ok", s_addr_ok, 2'b01);
    step(); set_port(0, 0, 2'd2, 32'h0000_0304, 0, 0); #1;
    chk("t4_ar_busy", s_addr_ok, 2'b00);
    step(); #1;
    chk("t4_rd2_ok", s_addr_ok, 2'b01);
    step(); set_port(0, 0, 2'd2, 32'h0000_0308, 0, 0); #1;
    chk("t4_ar_busy2", s_addr_ok, 2'b00);
    step(); #1;
    chk("t4_limit", s_addr_ok, 2'b00);
    step(); #1;
    chk("t4_limit2", s_addr_ok, 2'b00);
    step(); rvalid = 1; rid = 0; rdata = 32'h0000_0300; #1;
    chk("t4_limit_ret", s_addr_ok, 2'b00);
    chk("t4_ret_ok", s_data_ok, 2'b01);
    step(); rvalid = 0; #1;
    chk("t4_rd3_ok", s_addr_ok, 2'b01);
    s_req = 0;
    step(); step(); rvalid = 1; rid = 0; #1;
    chk("t4_ret2_ok", s_data_ok, 2'b01);
    step(); rid = 0; #1;
    chk("t4_ret3_ok", s_data_ok, 2'b01);
    step(); rvalid = 0; arready = 0;

    // 6: reset in the middle of a write
    set_port(0, 1, 2'd2, 32'h0000_0400, 32'hA5A5_A5A5, 4'hF);
    s_req = 2'b01; #1;
    chk("t6_wr_ok", s_addr_ok, 2'b01);
    step(); set_port(1, 0, 2'd2, 32'h0000_0800, 0, 0); s_req = 2'b10; #1;
    chk("t6_awvalid", awvalid, 1);
    chk("t6_rd_no_hazard", s_addr_ok, 2'b10);
    step(); s_req = 0; #1;
    chk("t6_arvalid", arvalid, 1);
    aresetn = 0; #1;
    chk("t6_rst_awvalid", awvalid, 0);
    chk("t6_rst_wvalid", wvalid, 0);
    chk("t6_rst_arvalid", arvalid, 0);
    step(); aresetn = 1;
    s_req = 2'b10; arready = 1; #1;
    chk("t6_rd1_ok", s_addr_ok, 2'b10);
    step(); #1;
    chk("t6_ar_busy", s_addr_ok, 2'b00);
    step(); #1;
    chk("t6_rd2_ok", s_addr_ok, 2'b10);
    step(); s_req = 2'b01; #1;
    chk("t6_wr_idle", s_addr_ok, 2'b01);
    s_req = 0;
    step(); step(); arready = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
